// File: rtl/delay_line_cal.sv
// -----------------------------------------------------------------------------
// delay_line_cal
//
// Calibration controller for a delay_line tap select. On start it sweeps every
// tap (0..15). For each tap it waits SETTLE_CYCLES so that the new tap has
// propagated through the delay line, then counts over 2^WINDOW_LOG2 cycles how
// often the delayed stream equals the reference stream. The tap with the
// highest count is programmed at the end of the sweep, and the lowest tap wins
// a tie. locked reports whether that tap matched on every sample.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   sweep request, sampled only while idle
//   ref_data    in   reference stream        [DATA_WIDTH-1:0]
//   dly_data    in   delay_line dout         [DATA_WIDTH-1:0]
//   delay       out  tap select to delay_line [3:0]
//   busy        out  sweep in progress
//   done        out  one-cycle pulse at the end of a sweep
//   locked      out  chosen tap matched for the whole window
//   best_count  out  match count of the chosen tap [WINDOW_LOG2:0]
//
// Per-tap period is SETTLE_CYCLES + 2^WINDOW_LOG2 + 1 cycles. done rises one
// cycle after the FINISH state, i.e. 16 periods + 1 cycle after start is taken.
// -----------------------------------------------------------------------------
module delay_line_cal #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned WINDOW_LOG2   = 8,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  ref_data,
    input  logic [DATA_WIDTH-1:0]  dly_data,
    output logic [3:0]             delay,
    output logic                   busy,
    output logic                   done,
    output logic                   locked,
    output logic [WINDOW_LOG2:0]   best_count
);

    // A full window: the count a perfectly aligned tap reaches.
    localparam logic [WINDOW_LOG2:0] FULL_COUNT  = {1'b1, {WINDOW_LOG2{1'b0}}};
    localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]           LAST_TAP    = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_FINISH
    } state_t;

    state_t                 state_q;
    logic [7:0]             settle_q;
    logic [WINDOW_LOG2-1:0] win_q;
    logic [WINDOW_LOG2:0]   match_q;
    logic [WINDOW_LOG2:0]   best_count_q;
    logic [3:0]             best_tap_q;
    logic [3:0]             delay_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   locked_q;

    // Combinational helpers feeding the state register.
    logic                   sample_hit_d;
    logic                   better_d;
    logic [WINDOW_LOG2:0]   match_d;

    assign sample_hit_d = (dly_data == ref_data);
    assign match_d      = sample_hit_d ? (match_q + 1'b1) : match_q;
    // Strictly greater: an equal count on a later tap never displaces an
    // earlier one, so ties resolve to the lowest tap and an all-zero sweep
    // leaves tap 0 selected.
    assign better_d     = (match_q > best_count_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            settle_q     <= '0;
            win_q        <= '0;
            match_q      <= '0;
            best_count_q <= '0;
            best_tap_q   <= '0;
            delay_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // done_q is only high in the cycle right after FINISH;
                    // a start seen in that cycle is dropped so the earliest
                    // restart is one cycle later.
                    if (start && !done_q) begin
                        locked_q     <= 1'b0;
                        best_count_q <= '0;
                        best_tap_q   <= '0;
                        delay_q      <= '0;
                        match_q      <= '0;
                        settle_q     <= '0;
                        win_q        <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    // Let the new tap flush through the delay line before
                    // any sample is taken.
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= '0;
                        state_q  <= S_MEASURE;
                    end else begin
                        settle_q <= settle_q + 8'd1;
                    end
                end

                S_MEASURE: begin
                    // Counter is one bit wider than the window index so a
                    // full-window match does not wrap to zero.
                    match_q <= match_d;
                    if (&win_q) begin
                        win_q   <= '0;
                        state_q <= S_COMPARE;
                    end else begin
                        win_q <= win_q + 1'b1;
                    end
                end

                S_COMPARE: begin
                    if (better_d) begin
                        best_count_q <= match_q;
                        best_tap_q   <= delay_q;
                    end
                    match_q <= '0;
                    if (delay_q != LAST_TAP) begin
                        delay_q <= delay_q + 4'd1;
                        state_q <= S_SETTLE;
                    end else begin
                        state_q <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    delay_q  <= best_tap_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    locked_q <= (best_count_q == FULL_COUNT);
                    state_q  <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign delay      = delay_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign locked     = locked_q;
    assign best_count = best_count_q;

endmodule

// File: tb/tb_delay_line_cal.sv
// -----------------------------------------------------------------------------
// tb_delay_line_cal
//
// Drives delay_line_cal with a behavioural plant that reacts to the DUT's
// delay output, and checks sweep timing and results against expectations
// computed from per-tap match counts (highest count wins, lowest tap on a
// tie, locked when a tap matches the whole window).
//
// Scenarios (mode):
//   0  exact alignment: ref = source delayed by 5, dly = source delayed by tap
//   1  no match: dly held at 0, ref random nonzero
//   2  tie: taps 3 and 7 match fully
//   3  partial: tap 9 matches 12/16, tap 2 matches 8/16
//   4  random per-tap match patterns
// Each sweep also pulses start while busy and in the done cycle.
// -----------------------------------------------------------------------------
module tb_delay_line_cal;

    localparam int DW      = 32;
    localparam int WL      = 4;
    localparam int SC      = 16;
    localparam int FULL    = 1 << WL;
    localparam int PERIOD  = SC + FULL + 1;
    localparam int DONE_AT = 16 * PERIOD + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] ref_data = '0;
    logic [DW-1:0] dly_data = '0;
    logic [3:0]    delay;
    logic          busy;
    logic          done;
    logic          locked;
    logic [WL:0]   best_count;

    always #5 clk = ~clk;

    delay_line_cal #(
        .DATA_WIDTH    (DW),
        .WINDOW_LOG2   (WL),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ref_data   (ref_data),
        .dly_data   (dly_data),
        .delay      (delay),
        .busy       (busy),
        .done       (done),
        .locked     (locked),
        .best_count (best_count)
    );

    int cyc = 0;
    int e0 = -100000;
    int mode = 1;
    int compared = 0;
    int mismatched = 0;
    bit rmatch [16][16];
    logic [DW-1:0] hist [16];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Whether sample k of tap t should match in a given scenario.
    function automatic bit want(input int m, input int t, input int k);
        case (m)
            0:       return (t == 5);
            1:       return 1'b0;
            2:       return (t == 3) || (t == 7);
            3: begin
                if (t == 9)      return (k % 4) != 0;
                else if (t == 2) return (k % 2) == 0;
                else             return 1'b0;
            end
            default: return rmatch[t][k];
        endcase
    endfunction

    // Plant: updates inputs 2 time units after each rising edge.
    initial begin
        int c;
        int k;
        for (int i = 0; i < 16; i++) hist[i] = $urandom;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = $urandom;
            c = cyc - e0;
            if (mode == 0) begin
                ref_data = hist[5];
                dly_data = hist[delay];
            end else if (mode == 1) begin
                ref_data = $urandom | 32'd1;
                dly_data = '0;
            end else begin
                ref_data = $urandom;
                if (c >= 0 && c < 16 * PERIOD && (c % PERIOD) >= SC && (c % PERIOD) < SC + FULL) begin
                    k = (c % PERIOD) - SC;
                    dly_data = want(mode, int'(delay), k) ? ref_data : (ref_data ^ ($urandom | 32'd1));
                end else begin
                    // Matches outside the window must never be counted.
                    dly_data = ref_data;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_delay"},  64'(delay),      64'd0);
        check({tag, "_busy"},   64'(busy),       64'd0);
        check({tag, "_done"},   64'(done),       64'd0);
        check({tag, "_locked"}, 64'(locked),     64'd0);
        check({tag, "_best"},   64'(best_count), 64'd0);
    endtask

    task automatic randomize_taps();
        int p;
        for (int t = 0; t < 16; t++) begin
            p = $urandom_range(0, 16);
            for (int k = 0; k < 16; k++) rmatch[t][k] = ($urandom_range(0, 15) < p);
        end
    endtask

    task automatic run_sweep(input int m);
        int cnt [16];
        int best_t;
        int best_c;
        int done_cnt;
        int done_at;
        mode = m;
        best_t = 0;
        best_c = 0;
        for (int t = 0; t < 16; t++) begin
            cnt[t] = 0;
            for (int k = 0; k < FULL; k++) cnt[t] += int'(want(m, t, k));
            if (cnt[t] > best_c) begin
                best_c = cnt[t];
                best_t = t;
            end
        end

        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; e0 = cyc;
        check("busy_after_start",   64'(busy),       64'd1);
        check("delay_after_start",  64'(delay),      64'd0);
        check("locked_cleared",     64'(locked),     64'd0);
        check("best_count_cleared", 64'(best_count), 64'd0);

        done_cnt = 0;
        done_at  = -1;
        for (int n = 1; n <= DONE_AT + 12; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                done_cnt++;
                done_at = n;
                start = 1'b1;               // must be ignored
            end else if (n == 40 || n == 300) begin
                start = 1'b1;               // sweep busy: must be ignored
            end
            if (m == 2 && n < 16 * PERIOD && ((n % PERIOD) == 0 || (n % PERIOD) == PERIOD - 1))
                check("delay_step", 64'(delay), 64'(n / PERIOD));
            if (done_at > 0 && n == done_at + 1)
                check("no_restart_from_done_cycle", 64'(busy), 64'd0);
        end
        start = 1'b0;

        check("done_count",  64'(done_cnt),   64'd1);
        check("done_time",   64'(done_at),    64'(DONE_AT));
        check("final_delay", 64'(delay),      64'(best_t));
        check("best_count",  64'(best_count), 64'(best_c));
        check("locked",      64'(locked),     64'(best_c == FULL));
        check("busy_idle",   64'(busy),       64'd0);
        $display("sweep mode=%0d tap=%0d best_count=%0d locked=%0d done_at=%0d",
                 m, delay, best_count, locked, done_at);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        run_sweep(0);
        run_sweep(1);
        run_sweep(2);
        run_sweep(3);
        randomize_taps();
        run_sweep(4);

        // Reset in the middle of a MEASURE window.
        randomize_taps();
        mode = 4;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; e0 = cyc;
        repeat (120) @(posedge clk);
        #1;
        check("busy_before_reset", 64'(busy), 64'd1);
        rst = 1'b1;
        #2;
        check_all_zero("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset mid-sweep applied at cycle %0d after start", 120);

        run_sweep(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
